// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one multiply-accumulate step per cycle walks NTAPS taps
// over a circular sample history, with valid/ready handshakes on both sides.
module fir_mac_sequencer #(
  parameter int N     = 32,
  parameter int NTAPS = 8,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic          coef_busy,
  input  logic          x_valid,
  input  logic [N-1:0]  x_data,
  output logic          x_ready,
  output logic          y_valid,
  output logic [N-1:0]  y_data,
  input  logic          y_ready
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_t        state_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] k_reg;
  logic [AW-1:0] hist_idx;
  logic [N-1:0]  acc_reg;
  logic [N-1:0]  acc_next;
  logic [N-1:0]  y_data_reg;
  logic          y_valid_reg;
  logic [N-1:0]  coef_rd;
  logic [N-1:0]  hist_rd;
  logic          idle_en;
  logic [N-1:0]  coef_word [NTAPS];
  logic [N-1:0]  hist_word [NTAPS];

  assign idle_en = ena && (state_reg == IDLE);

  // Per-tap storage is plain registers because reset must clear every entry.
  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      logic [N-1:0] coef_reg;
      logic [N-1:0] hist_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          coef_reg <= '0;
          hist_reg <= '0;
        end else begin
          if (idle_en && coef_we && (coef_addr == AW'(gi)))
            coef_reg <= coef_data;
          if (idle_en && x_valid && (wr_ptr_reg == AW'(gi)))
            hist_reg <= x_data;
        end
      end
      assign coef_word[gi] = coef_reg;
      assign hist_word[gi] = hist_reg;
    end
  endgenerate

  // x[n-k] lives at (wr_ptr - k) mod NTAPS; wrap handled without power-of-2 masking.
  always_comb begin
    if (k_reg > wr_ptr_reg)
      hist_idx = AW'(NTAPS + int'(wr_ptr_reg) - int'(k_reg));
    else
      hist_idx = wr_ptr_reg - k_reg;
  end

  assign coef_rd  = coef_word[k_reg];
  assign hist_rd  = hist_word[hist_idx];
  // Low N bits of the product are identical to truncating the full 2N-bit product.
  assign acc_next = acc_reg + coef_rd * hist_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      k_reg       <= '0;
      acc_reg     <= '0;
      y_valid_reg <= 1'b0;
      y_data_reg  <= '0;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          if (x_valid) begin
            acc_reg   <= '0;
            k_reg     <= '0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_next;
          if (k_reg == K_LAST) begin
            k_reg       <= '0;
            y_data_reg  <= acc_next;
            y_valid_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          if (y_ready) begin
            y_valid_reg <= 1'b0;
            wr_ptr_reg  <= (wr_ptr_reg == K_LAST) ? '0 : wr_ptr_reg + 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign x_ready   = (state_reg == IDLE);
  assign coef_busy = (state_reg != IDLE);
  assign y_valid   = y_valid_reg;
  assign y_data    = y_data_reg;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with NTAPS=4: vector tables plus
// hand-written backpressure, ena gating, reset and wrap sequences.
module tb_fir_mac_sequencer;
  localparam int N     = 32;
  localparam int NTAPS = 4;
  localparam int AW    = $clog2(NTAPS);

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic          coef_busy;
  logic          x_valid;
  logic [N-1:0]  x_data;
  logic          x_ready;
  logic          y_valid;
  logic [N-1:0]  y_data;
  logic          y_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
  } vec_t;

  vec_t tbl_main [11];
  vec_t tbl_post [6];
  vec_t tbl_rst  [10];

  logic [N-1:0] mb [NTAPS];
  logic [N-1:0] mh [NTAPS];

  fir_mac_sequencer #(.N(N), .NTAPS(NTAPS)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_coef(input int addr, input logic [N-1:0] data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic load_coefs(input logic [N-1:0] b0, input logic [N-1:0] b1,
                            input logic [N-1:0] b2, input logic [N-1:0] b3);
    write_coef(0, b0);
    write_coef(1, b1);
    write_coef(2, b2);
    write_coef(3, b3);
  endtask

  // One full transaction: accept, count cycles to y_valid, check, then drain.
  task automatic run_vector(input logic [N-1:0] x, input logic [N-1:0] exp_y, input string tag);
    int lat;
    check({tag, "_xready"}, N'(x_ready), N'(1));
    x_valid = 1'b1;
    x_data  = x;
    tick();
    x_valid = 1'b0;
    lat = 0;
    while (!y_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, N'(lat), N'(NTAPS));
    check({tag, "_y"}, y_data, exp_y);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    check({tag, "_drain"}, N'(y_valid), N'(0));
    $display("xfer %s x=%h y=%h expected=%h lat=%0d", tag, x, y_data, exp_y, lat);
  endtask

  initial begin
    int c;
    logic seen;
    logic [N-1:0] xv;
    logic [N-1:0] ey;

    // Impulse then step, b={1,2,3,4}
    tbl_main[0]  = '{32'd1, 32'd1};
    tbl_main[1]  = '{32'd0, 32'd2};
    tbl_main[2]  = '{32'd0, 32'd3};
    tbl_main[3]  = '{32'd0, 32'd4};
    tbl_main[4]  = '{32'd0, 32'd0};
    tbl_main[5]  = '{32'd5, 32'd5};
    tbl_main[6]  = '{32'd5, 32'd15};
    tbl_main[7]  = '{32'd5, 32'd30};
    tbl_main[8]  = '{32'd5, 32'd50};
    tbl_main[9]  = '{32'd5, 32'd50};
    tbl_main[10] = '{32'd5, 32'd50};
    // After the backpressured x=0 (history 0,5,5,5): drain then impulse proves b unchanged
    tbl_post[0] = '{32'd0, 32'd35};
    tbl_post[1] = '{32'd0, 32'd20};
    tbl_post[2] = '{32'd1, 32'd1};
    tbl_post[3] = '{32'd0, 32'd2};
    tbl_post[4] = '{32'd0, 32'd3};
    tbl_post[5] = '{32'd0, 32'd4};
    // After reset: coefficients are zero, flush, then reload and impulse
    tbl_rst[0] = '{32'd7, 32'd0};
    tbl_rst[1] = '{32'd0, 32'd0};
    tbl_rst[2] = '{32'd0, 32'd0};
    tbl_rst[3] = '{32'd0, 32'd0};
    tbl_rst[4] = '{32'd0, 32'd0};
    tbl_rst[5] = '{32'd1, 32'd1};
    tbl_rst[6] = '{32'd0, 32'd2};
    tbl_rst[7] = '{32'd0, 32'd3};
    tbl_rst[8] = '{32'd0, 32'd4};
    tbl_rst[9] = '{32'd0, 32'd0};

    rst = 1'b1; ena = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    tick();
    tick();
    check("rst_y_valid", N'(y_valid), N'(0));
    check("rst_y_data", y_data, N'(0));
    check("rst_x_ready", N'(x_ready), N'(1));
    check("rst_coef_busy", N'(coef_busy), N'(0));
    rst = 1'b0;

    load_coefs(32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 11; i++)
      run_vector(tbl_main[i].x, tbl_main[i].y, $sformatf("main%0d", i));

    // Backpressure: history 5,5,5,5 then x=0 -> 0*1+5*2+5*3+5*4 = 45
    x_valid = 1'b1; x_data = '0;
    tick();
    x_valid = 1'b0;
    c = 0;
    while (!y_valid && c < 40) begin tick(); c++; end
    check("bp_latency", N'(c), N'(NTAPS));
    coef_we = 1'b1; coef_addr = '0; coef_data = 32'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_y_valid", N'(y_valid), N'(1));
      check("bp_y_data", y_data, 32'd45);
      check("bp_x_ready", N'(x_ready), N'(0));
      check("bp_coef_busy", N'(coef_busy), N'(1));
    end
    coef_we = 1'b0;
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    check("bp_release_x_ready", N'(x_ready), N'(1));
    check("bp_release_y_valid", N'(y_valid), N'(0));
    check("bp_release_y_data", y_data, 32'd45);
    $display("xfer bp x=0 y=%h held 3 cycles", y_data);
    for (int i = 0; i < 6; i++)
      run_vector(tbl_post[i].x, tbl_post[i].y, $sformatf("post%0d", i));

    // Overflow: b0 = all ones, x=2 -> 0xFFFFFFFE
    load_coefs(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    run_vector(32'd2, 32'hFFFF_FFFE, "ovf");

    // ena gating: history 2,0,0,0; x=3 with b={1,2,3,4} -> 3*1+2*2 = 7
    load_coefs(32'd1, 32'd2, 32'd3, 32'd4);
    x_valid = 1'b1; x_data = 32'd3;
    tick();
    x_valid = 1'b0;
    tick();
    tick();
    c = 2;
    ena = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      c++;
      if (y_valid || x_ready) seen = 1'b1;
    end
    check("ena_frozen", N'(seen), N'(0));
    ena = 1'b1;
    while (!y_valid && c < 60) begin tick(); c++; end
    check("ena_latency", N'(c), N'(NTAPS + 5));
    check("ena_y", y_data, 32'd7);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    $display("xfer ena x=3 y=%h cycles=%0d", y_data, c);

    // Simultaneous coef write and sample: history 1,3,2,0 with b={10,2,3,4} -> 22
    coef_we = 1'b1; coef_addr = '0; coef_data = 32'd10;
    run_vector(32'd1, 32'd22, "simul");
    coef_we = 1'b0;

    // Reset at k=2 abandons the result and clears coefficients and history
    x_valid = 1'b1; x_data = 32'd9;
    tick();
    x_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_y_valid", N'(y_valid), N'(0));
    check("mid_rst_x_ready", N'(x_ready), N'(1));
    check("mid_rst_coef_busy", N'(coef_busy), N'(0));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (y_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", N'(seen), N'(0));
    for (int i = 0; i < 5; i++)
      run_vector(tbl_rst[i].x, tbl_rst[i].y, $sformatf("rst%0d", i));
    load_coefs(32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 5; i < 10; i++)
      run_vector(tbl_rst[i].x, tbl_rst[i].y, $sformatf("rst%0d", i));

    // Wrap: 2*NTAPS+1 samples against a shift-register reference, history starts at zero
    mb[0] = 32'd3; mb[1] = 32'h0001_0000; mb[2] = 32'd7; mb[3] = 32'h8000_0001;
    for (int j = 0; j < NTAPS; j++) mh[j] = '0;
    load_coefs(mb[0], mb[1], mb[2], mb[3]);
    for (int i = 0; i < 2 * NTAPS + 1; i++) begin
      xv = 32'h89AB_CDEF + 32'(i) * 32'h0123_4567;
      for (int j = NTAPS - 1; j > 0; j--) mh[j] = mh[j-1];
      mh[0] = xv;
      ey = '0;
      for (int j = 0; j < NTAPS; j++) ey = ey + mb[j] * mh[j];
      run_vector(xv, ey, $sformatf("wrap%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller. One multiply-accumulate unit is shared across NTAPS taps, with the unit computing y = b*x + y_in for one tap per cycle. The block holds the coefficient RAM and a circular sample history, and accepts one input sample per valid/ready handshake. It sequences NTAPS MAC cycles and presents the filter output on a valid/ready handshake. It replaces a fully unrolled tapped-delay chain where area matters more than throughput.

Parameters:
N, 32, data/coefficient/accumulator width in bits
NTAPS, 8, number of filter taps (>=2, any integer, not required to be a power of 2)
AW, $clog2(NTAPS), tap index / coefficient address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
ena  input  1  clock enable; when low, every register holds its value and handshakes are frozen
coef_we  input  1  coefficient write strobe
coef_addr  input  AW  coefficient index k (b[k] multiplies x[n-k])
coef_data  input  N  coefficient value
coef_busy  output  1  high when a coefficient write would be ignored
x_valid  input  1  input sample valid
x_data  input  N  input sample
x_ready  output  1  block can accept a sample
y_valid  output  1  output sample valid
y_data  output  N  filter output
y_ready  input  1  downstream accepts output

Behaviour:
- Reset (rst=1 at a clock edge, overrides ena):
  - state=IDLE, wr_ptr=0, k=0, acc=0.
  - All NTAPS history entries and all NTAPS coefficients are cleared to 0.
  - Outputs: y_valid=0, y_data=0, x_ready=1, coef_busy=0.
  - Reset mid-MAC or mid-DONE abandons the result; no y_valid is produced for it.
- States are IDLE, MAC and DONE. x_ready=(state==IDLE); coef_busy=(state!=IDLE). All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - Coefficient write: coef_we=1 with ena=1 writes b[coef_addr]=coef_data. A coef_addr >= NTAPS is ignored.
  - Sample accept: x_valid=1 with ena=1 writes hist[wr_ptr]=x_data, sets acc=0 and k=0, and moves to MAC.
  - If coef_we and x_valid arrive in the same IDLE cycle, both take effect. The new coefficient is used by this sample's computation.
- MAC: each enabled cycle does acc <= acc + b[k]*hist[(wr_ptr-k) mod NTAPS], then k <= k+1.
  - The history index wraps 0 -> NTAPS-1 explicitly, with no power-of-2 assumption.
  - After the cycle with k=NTAPS-1: y_data <= final acc, y_valid <= 1, state <= DONE.
- Latency: with ena held high, acceptance happens at edge E0 and y_valid rises after edge E_NTAPS. Throughput is at most one sample per NTAPS+2 cycles.
- DONE:
  - y_valid and y_data hold stable until a cycle with y_ready=1 and ena=1.
  - On that cycle: y_valid <= 0, wr_ptr <= (wr_ptr+1) mod NTAPS, state <= IDLE. y_data keeps its last value.
- Arithmetic:
  - The product b*x is computed 2N wide and truncated to its low N bits.
  - The accumulator is N bits and wraps modulo 2^N, with no saturation.
  - Operands are treated as unsigned bit patterns. Two's-complement signed data gives correct results modulo 2^N.
- Ignored inputs:
  - coef_we in MAC or DONE is dropped; no coefficient changes.
  - x_valid in MAC or DONE is not accepted (x_ready=0); the producer must hold x_data.
- ena=0 in any state: no state, counter, accumulator, pointer or memory update, and no handshake completes.

Test Plan:
- Impulse, NTAPS=4: load b={1,2,3,4}; send x=1,0,0,0,0 -> y=1,2,3,4,0. Check y_valid rises exactly 4 cycles after each x accept edge.
- Step, NTAPS=4: same b; send x=5 six times -> y=5,15,30,50,50,50.
- Backpressure: hold y_ready=0 for 3 cycles in DONE -> y_valid/y_data stable, x_ready=0, coef write during DONE ignored (readback via later impulse unchanged); y_ready=1 -> back to IDLE next cycle.
- Wrap/overflow: b[0]=0xFFFFFFFF, others 0; x=2 -> y=0xFFFFFFFE. Then run 2*NTAPS+1 impulses to exercise wr_ptr wrap; the response matches a reference model.
- Reset mid-MAC: assert rst at k=2 -> no y_valid, x_ready=1 next cycle, coefficients 0. Reload b={1,2,3,4} and send an impulse -> 1,2,3,4.
- ena gating: deassert ena for 5 cycles during MAC -> completion is delayed by exactly 5 cycles and y is unchanged. Simultaneous coef_we+x_valid in IDLE -> the new b[0] is applied to that sample.
